shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter STEP, default 4, SHALL set the maximum bit-positions shifted per SHIFT cycle; legal range 1..8.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 op_valid  in  1  operation request valid.
REQ-005 op_ready  out  1  sequencer can accept an operation.
REQ-006 op_mode  in  3  000 SHL, 001 ASR, 010 LSR, 011 ROL, 100 ROR, 101 RCL, 110 RCR, 111 illegal.
REQ-007 op_data  in  16  operand.
REQ-008 op_amt  in  5  shift/rotate amount, 0..31.
REQ-009 op_carry  in  1  carry-in flag.
REQ-010 res_valid  out  1  result valid.
REQ-011 res_ready  in  1  consumer accepts result.
REQ-012 res_data  out  16  result.
REQ-013 res_carry / res_zero / res_neg / res_err  out  1 each  carry, zero, sign, illegal-mode flags.

Function
REQ-014 States: IDLE, SHIFT, DONE; op_ready SHALL equal (state==IDLE); res_valid SHALL equal (state==DONE).
REQ-015 Accept = op_valid & op_ready; on accept: load 17-bit work register {op_carry, op_data}, remaining <= op_amt, latch mode.
REQ-016 IDLE -> SHIFT on accept with op_amt!=0 and legal mode; IDLE -> DONE on accept with op_amt==0 or mode 111.
REQ-017 Each SHIFT cycle SHALL shift by s = min(remaining, STEP) and set remaining <= remaining - s; SHIFT -> DONE when remaining reaches 0.
REQ-018 Result SHALL equal op_amt successive 1-bit operations of the mode (no modulo reduction of op_amt).
REQ-019 SHL/LSR: zero fill, carry = last bit shifted out; amt>=17 gives data 0, carry 0.
REQ-020 ASR: fill with bit 15, carry = last bit out; amt>=16 gives data {16{sign}}, carry = sign.
REQ-021 ROL/ROR: 16-bit rotate; carry = bit last rotated (ROL: res[0], ROR: res[15]); carry unchanged when amt==0.
REQ-022 RCL/RCR: 17-bit rotate through {carry,data}.
REQ-023 Mode 111: res_data = op_data, res_carry = op_carry, res_err = 1; all legal modes give res_err = 0.
REQ-024 res_zero = (res_data==0); res_neg = res_data[15].
REQ-025 Latency: res_valid SHALL rise exactly 1 + ceil(op_amt/STEP) rising edges after the accept edge (1 for amt 0 or illegal).
REQ-026 DONE: res_* SHALL hold stable while res_ready=0; DONE -> IDLE on res_ready=1; no new accept in DONE (no overlap).
REQ-027 op_* inputs SHALL be ignored outside the accept cycle.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, remaining 0, work register 0; rst has priority over every transition.
REQ-029 After reset: op_ready=1, res_valid=0, res_data=0, res_carry=res_zero=res_neg=res_err=0 (res_zero forced 0 while not valid).
REQ-030 Reset during SHIFT or DONE SHALL discard the in-flight operation with no result produced.

Structure
REQ-031 Package shift_pkg SHALL hold mode encodings, state enumeration and STEP default.
REQ-032 One combinational sub-module shift_step SHALL perform a single pass of 0..STEP bits on the 17-bit {carry,data} per mode; the sequencer owns all state.

Verification
REQ-033 SHL 0x8001, amt 1, carry 0 -> res 0x0002, carry 1, valid 2 edges after accept.
REQ-034 ASR 0x8000, amt 20, STEP 4 -> res 0xFFFF, carry 1, neg 1, zero 0, valid 6 edges after accept.
REQ-035 ROR 0x0001 amt 1 -> 0x8000 carry 1; RCL 0x0001 carry 1 amt 17 -> 0x0001 carry 1.
REQ-036 LSR 0x1234 amt 0 carry 1 with res_ready low 3 cycles -> 0x1234, carry 1, outputs stable, op_ready 0 throughout, IDLE one edge after res_ready rises.
REQ-037 Mode 111, data 0x00FF -> res 0x00FF, res_err 1, latency 1.
REQ-038 rst pulsed mid-SHIFT (SHL amt 31) -> next cycle op_ready 1, res_valid 0, all outputs 0; following op executes correctly.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift/rotate sequencer.
package shift_pkg;

  localparam int unsigned STEP_DEFAULT = 4;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned AMT_W        = 5;
  localparam int unsigned MODE_W       = 3;
  localparam int unsigned CNT_W        = 4;

  typedef enum logic [MODE_W-1:0] {
    MODE_SHL = 3'b000,
    MODE_ASR = 3'b001,
    MODE_LSR = 3'b010,
    MODE_ROL = 3'b011,
    MODE_ROR = 3'b100,
    MODE_RCL = 3'b101,
    MODE_RCR = 3'b110,
    MODE_ILL = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Carry sits above the data word so RCL/RCR see one 17-bit ring.
  typedef struct packed {
    logic              carry;
    logic [DATA_W-1:0] data;
  } work_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Operation request / result handshake bundle for shift_sequencer.
interface shift_sequencer_if;
  import shift_pkg::*;

  logic              op_valid;
  logic              op_ready;
  logic [MODE_W-1:0] op_mode;
  logic [DATA_W-1:0] op_data;
  logic [AMT_W-1:0]  op_amt;
  logic              op_carry;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_carry;
  logic              res_zero;
  logic              res_neg;
  logic              res_err;

  modport master (
    output op_valid, op_mode, op_data, op_amt, op_carry, res_ready,
    input  op_ready, res_valid, res_data, res_carry, res_zero, res_neg, res_err
  );

  modport slave (
    input  op_valid, op_mode, op_data, op_amt, op_carry, res_ready,
    output op_ready, res_valid, res_data, res_carry, res_zero, res_neg, res_err
  );

endinterface

// File: rtl/shift_step.sv
// Combinational pass applying 0..STEP single-bit operations to {carry,data}.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned STEP = STEP_DEFAULT
) (
  input  mode_e              i_mode,
  input  work_t              i_work,
  input  logic [CNT_W-1:0]   i_cnt,
  output work_t              o_work
);

  function automatic work_t step1(mode_e m, work_t w);
    work_t r;
    r = w;
    case (m)
      MODE_SHL: r = {w.data[15], w.data[14:0], 1'b0};
      MODE_ASR: r = {w.data[0],  w.data[15],   w.data[15:1]};
      MODE_LSR: r = {w.data[0],  1'b0,         w.data[15:1]};
      MODE_ROL: r = {w.data[15], w.data[14:0], w.data[15]};
      MODE_ROR: r = {w.data[0],  w.data[0],    w.data[15:1]};
      MODE_RCL: r = {w.data[15], w.data[14:0], w.carry};
      MODE_RCR: r = {w.data[0],  w.carry,      w.data[15:1]};
      default:  r = w;
    endcase
    return r;
  endfunction

  work_t w_acc;

  // Unrolled chain; stages beyond i_cnt pass through unchanged.
  always_comb begin
    w_acc = i_work;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (i < 32'(i_cnt)) w_acc = step1(i_mode, w_acc);
    end
    o_work = w_acc;
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: up to STEP bit positions per SHIFT cycle.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned STEP = STEP_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  shift_sequencer_if.slave bus
);

  state_e             r_state;
  state_e             w_next;
  work_t              r_work;
  work_t              w_step_work;
  logic [AMT_W-1:0]   r_rem;
  mode_e              r_mode;
  logic               r_err;
  mode_e              w_mode_in;
  logic               w_accept;
  logic [CNT_W-1:0]   w_step_cnt;

  assign w_mode_in  = mode_e'(bus.op_mode);
  assign w_accept   = bus.op_valid && (r_state == ST_IDLE);
  assign w_step_cnt = (r_rem < AMT_W'(STEP)) ? CNT_W'(r_rem) : CNT_W'(STEP);

  shift_step #(.STEP(STEP)) u_step (
    .i_mode (r_mode),
    .i_work (r_work),
    .i_cnt  (w_step_cnt),
    .o_work (w_step_work)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_mode_in == MODE_ILL || bus.op_amt == '0) w_next = ST_DONE;
          else                                           w_next = ST_SHIFT;
        end
      end
      ST_SHIFT: if (r_rem == AMT_W'(w_step_cnt)) w_next = ST_DONE;
      ST_DONE:  if (bus.res_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Work register is only disturbed by accept and by SHIFT cycles, so it holds in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= '0;
      r_rem  <= '0;
      r_mode <= MODE_SHL;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_work <= {bus.op_carry, bus.op_data};
      r_rem  <= bus.op_amt;
      r_mode <= w_mode_in;
      r_err  <= (w_mode_in == MODE_ILL);
    end else if (r_state == ST_SHIFT) begin
      r_work <= w_step_work;
      r_rem  <= r_rem - AMT_W'(w_step_cnt);
    end
  end

  // Result fields are gated to zero whenever no result is being presented.
  assign bus.op_ready  = (r_state == ST_IDLE);
  assign bus.res_valid = (r_state == ST_DONE);
  assign bus.res_data  = bus.res_valid ? r_work.data : '0;
  assign bus.res_carry = bus.res_valid & r_work.carry;
  assign bus.res_zero  = bus.res_valid & (r_work.data == '0);
  assign bus.res_neg   = bus.res_valid & r_work.data[DATA_W-1];
  assign bus.res_err   = bus.res_valid & r_err;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed plus randomized bench for shift_sequencer against an arithmetic reference model.
module tb_shift_sequencer;
  import shift_pkg::*;

  localparam int unsigned STEP = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  shift_sequencer_if bus ();

  shift_sequencer #(.STEP(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-amount shifts/rotates on widened vectors; returns {err, carry, data}.
  function automatic logic [17:0] model(input logic [2:0] mode, input logic [15:0] d,
                                        input logic [4:0] amt, input logic c);
    logic [47:0]        x;
    logic signed [47:0] sx;
    logic [31:0]        t;
    logic [33:0]        u;
    logic [16:0]        v;
    int                 r;
    if (mode == 3'b111) return {1'b1, c, d};
    if (amt == 5'd0)    return {1'b0, c, d};
    v = {c, d};
    case (mode)
      3'b000: begin x = 48'(d) << amt;                 return {1'b0, x[16], x[15:0]}; end
      3'b010: begin x = {d, 32'h0} >> amt;             return {1'b0, x[31], x[47:32]}; end
      3'b001: begin sx = $signed({d, 32'h0}) >>> amt;  return {1'b0, sx[31], sx[47:32]}; end
      3'b011: begin r = int'(amt) % 16; t = {d, d} << r; return {1'b0, t[16], t[31:16]}; end
      3'b100: begin r = int'(amt) % 16; t = {d, d} >> r; return {1'b0, t[15], t[15:0]}; end
      3'b101: begin r = int'(amt) % 17; u = {v, v} << r; return {1'b0, u[33:17]}; end
      default: begin r = int'(amt) % 17; u = {v, v} >> r; return {1'b0, u[16:0]}; end
    endcase
  endfunction

  task automatic scramble();
    bus.op_mode  = 3'($urandom);
    bus.op_data  = 16'($urandom);
    bus.op_amt   = 5'($urandom);
    bus.op_carry = 1'($urandom);
  endtask

  task automatic run_op(input logic [2:0] mode, input logic [15:0] d, input logic [4:0] amt,
                        input logic c, input int hold, input string tag);
    logic [17:0] exp;
    int          lat;
    int          exp_lat;
    exp     = model(mode, d, amt, c);
    exp_lat = (mode == 3'b111 || amt == 5'd0) ? 1 : 1 + (int'(amt) + STEP - 1) / STEP;
    check({tag, "_ready"}, 32'(bus.op_ready), 32'd1);
    bus.op_mode  = mode;
    bus.op_data  = d;
    bus.op_amt   = amt;
    bus.op_carry = c;
    bus.op_valid = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    scramble();
    lat = 1;
    while (!bus.res_valid && lat < 100) begin
      @(posedge clk); #1;
      scramble();
      lat++;
    end
    check({tag, "_lat"},   32'(lat),           32'(exp_lat));
    check({tag, "_data"},  32'(bus.res_data),  32'(exp[15:0]));
    check({tag, "_carry"}, 32'(bus.res_carry), 32'(exp[16]));
    check({tag, "_zero"},  32'(bus.res_zero),  32'(exp[15:0] == 16'h0));
    check({tag, "_neg"},   32'(bus.res_neg),   32'(exp[15]));
    check({tag, "_err"},   32'(bus.res_err),   32'(exp[17]));
    check({tag, "_busy"},  32'(bus.op_ready),  32'd0);
    // Offer a new op while stalled; it must not be taken.
    for (int i = 0; i < hold; i++) begin
      bus.op_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, "_hold_data"},  32'(bus.res_data),  32'(exp[15:0]));
      check({tag, "_hold_carry"}, 32'(bus.res_carry), 32'(exp[16]));
      check({tag, "_hold_valid"}, 32'(bus.res_valid), 32'd1);
      check({tag, "_hold_busy"},  32'(bus.op_ready),  32'd0);
    end
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check({tag, "_idle"},    32'(bus.op_ready),  32'd1);
    check({tag, "_novalid"}, 32'(bus.res_valid), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ready"}, 32'(bus.op_ready),  32'd1);
    check({tag, "_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_data"},  32'(bus.res_data),  32'd0);
    check({tag, "_flags"}, 32'({bus.res_carry, bus.res_zero, bus.res_neg, bus.res_err}), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b0;
    bus.op_mode   = '0;
    bus.op_data   = '0;
    bus.op_amt    = '0;
    bus.op_carry  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    rst = 1'b0;

    run_op(3'b000, 16'h8001, 5'd1,  1'b0, 0, "shl_8001_1");
    run_op(3'b001, 16'h8000, 5'd20, 1'b0, 0, "asr_8000_20");
    run_op(3'b100, 16'h0001, 5'd1,  1'b0, 0, "ror_0001_1");
    run_op(3'b101, 16'h0001, 5'd17, 1'b1, 0, "rcl_0001_17");
    run_op(3'b010, 16'h1234, 5'd0,  1'b1, 3, "lsr_amt0_stall");
    run_op(3'b111, 16'h00FF, 5'd5,  1'b0, 0, "illegal");
    run_op(3'b000, 16'hFFFF, 5'd17, 1'b1, 0, "shl_17");
    run_op(3'b011, 16'h8421, 5'd0,  1'b1, 0, "rol_amt0");

    // Reset in the middle of a long SHL must drop the operation.
    bus.op_mode  = 3'b000;
    bus.op_data  = 16'hA5A5;
    bus.op_amt   = 5'd31;
    bus.op_carry = 1'b1;
    bus.op_valid = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_cleared("midshift_rst");
    repeat (3) begin @(posedge clk); #1; end
    check_cleared("midshift_rst_quiet");
    run_op(3'b011, 16'h8001, 5'd3, 1'b0, 1, "rol_after_rst");

    for (int k = 0; k < 40; k++) begin
      run_op(3'($urandom), 16'($urandom), 5'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
